// File: rtl/instruction_aligner.sv
// Fetch-side realignment: word fetches into a 4-halfword queue, one whole RVC or
// 32-bit instruction presented per handshake, with PC tracking and redirects.
module instruction_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        fetch_req_out,
    output logic [31:0] fetch_addr_out,
    input  logic [31:0] fetch_word_in,
    input  logic        fetch_valid_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out,
    output logic        instr_compressed_out,
    output logic        instr_valid_out,
    input  logic        instr_ready_in
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state_reg, state_next;
    logic [3:0][15:0]  queue_reg, queue_next;
    logic [2:0]        count_reg, count_next;
    logic [31:0]       pc_reg, pc_next;
    logic [31:0]       addr_reg, addr_next;
    logic              discard_reg, discard_next;
    logic              skip_low_reg, skip_low_next;

    logic              head_rvc;
    logic              consume;
    logic              push_word;
    logic [2:0]        pop_cnt;
    logic [2:0]        push_cnt;
    logic [2:0]        base;

    // Outputs depend only on queue registers, never on the incoming word.
    assign head_rvc             = queue_reg[0][1:0] != 2'b11;
    assign instr_valid_out      = (count_reg >= 3'd1 && head_rvc) || count_reg >= 3'd2;
    assign instr_compressed_out = instr_valid_out && head_rvc;
    assign instr_pc_out         = pc_reg;
    assign fetch_addr_out       = addr_reg;

    always_comb begin
        instr_out = 32'h0;
        if (instr_valid_out) begin
            instr_out = head_rvc ? {16'h0, queue_reg[0]} : {queue_reg[1], queue_reg[0]};
        end
    end

    assign consume   = instr_valid_out && instr_ready_in;
    assign pop_cnt   = !consume ? 3'd0 : (head_rvc ? 3'd1 : 3'd2);
    assign push_word = state_reg == WAIT && fetch_valid_in && !discard_reg && !redirect_in;
    assign push_cnt  = !push_word ? 3'd0 : (skip_low_reg ? 3'd1 : 3'd2);
    assign base      = count_reg - pop_cnt;

    // Each entry takes the shifted-down value after a pop, or a pushed half
    // landing just behind the surviving entries.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_entry
            logic [15:0] shift1, shift2, entry_next;
            if (gi < 3) begin : g_s1
                assign shift1 = queue_reg[gi+1];
            end else begin : g_s1_top
                assign shift1 = queue_reg[gi];
            end
            if (gi < 2) begin : g_s2
                assign shift2 = queue_reg[gi+2];
            end else begin : g_s2_top
                assign shift2 = queue_reg[gi];
            end
            always_comb begin
                entry_next = queue_reg[gi];
                if (pop_cnt == 3'd1) begin
                    entry_next = shift1;
                end else if (pop_cnt == 3'd2) begin
                    entry_next = shift2;
                end
                if (push_word) begin
                    if (skip_low_reg) begin
                        if (base == 3'(gi)) entry_next = fetch_word_in[31:16];
                    end else if (base == 3'(gi)) begin
                        entry_next = fetch_word_in[15:0];
                    end else if (base + 3'd1 == 3'(gi)) begin
                        entry_next = fetch_word_in[31:16];
                    end
                end
            end
            assign queue_next[gi] = entry_next;
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        fetch_req_out = 1'b0;
        addr_next     = addr_reg;
        discard_next  = discard_reg;
        skip_low_next = skip_low_reg;
        count_next    = count_reg - pop_cnt + push_cnt;
        pc_next       = pc_reg + {28'd0, pop_cnt, 1'b0};
        case (state_reg)
            IDLE: begin
                if (count_reg <= 3'd2 && !redirect_in && !rst) begin
                    fetch_req_out = 1'b1;
                    addr_next     = addr_reg + 32'd4;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                if (fetch_valid_in) begin
                    state_next   = IDLE;
                    discard_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
        if (push_word) skip_low_next = 1'b0;
        // A redirect wins over any consume or push in the same cycle.
        if (redirect_in) begin
            count_next    = 3'd0;
            pc_next       = redirect_pc_in & ~32'h1;
            addr_next     = redirect_pc_in & ~32'h3;
            skip_low_next = redirect_pc_in[1];
            discard_next  = state_reg == WAIT && !fetch_valid_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            queue_reg    <= '0;
            count_reg    <= 3'd0;
            pc_reg       <= RESET_PC & ~32'h1;
            addr_reg     <= RESET_PC & ~32'h3;
            discard_reg  <= 1'b0;
            skip_low_reg <= RESET_PC[1];
        end else begin
            state_reg    <= state_next;
            queue_reg    <= queue_next;
            count_reg    <= count_next;
            pc_reg       <= pc_next;
            addr_reg     <= addr_next;
            discard_reg  <= discard_next;
            skip_low_reg <= skip_low_next;
        end
    end
endmodule

// File: tb/tb_instruction_aligner.sv
// Bench for instruction_aligner: memory model with programmable latency and a
// scoreboard of expected instructions filled from a vector table.
module tb_instruction_aligner;
    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req_out;
    logic [31:0] fetch_addr_out;
    logic [31:0] fetch_word_in;
    logic        fetch_valid_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_compressed_out;
    logic        instr_valid_out;
    logic        instr_ready_in;

    always #5 clk = ~clk;

    instruction_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fetch_req_out        (fetch_req_out),
        .fetch_addr_out       (fetch_addr_out),
        .fetch_word_in        (fetch_word_in),
        .fetch_valid_in       (fetch_valid_in),
        .redirect_in          (redirect_in),
        .redirect_pc_in       (redirect_pc_in),
        .instr_out            (instr_out),
        .instr_pc_out         (instr_pc_out),
        .instr_compressed_out (instr_compressed_out),
        .instr_valid_out      (instr_valid_out),
        .instr_ready_in       (instr_ready_in)
    );

    typedef struct {
        int          grp;
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    vec_t        tbl [11];
    exp_t        sb [$];
    logic [31:0] mem [logic [31:0]];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_req = 0;
    int          first_cons_cyc = -1;
    int          last_cons_cyc = -1;
    int          last_req_cyc = 0;
    int          last_resp_cyc = 0;
    bit          pend = 1'b0;
    int          pend_wait = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] last_req_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: observe this cycle's outputs, step the edge, then drive the
    // memory response for the new cycle.
    task automatic cycle();
        exp_t e;
        #1;
        if (instr_valid_out && instr_ready_in) begin
            if (first_cons_cyc < 0) first_cons_cyc = cyc;
            last_cons_cyc = cyc;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_instr: got %h @ %h, expected none", instr_out, instr_pc_out);
            end else begin
                e = sb.pop_front();
                $display("cyc %0d: instr %h pc %h c %0b (want %h pc %h c %0b)", cyc, instr_out,
                         instr_pc_out, instr_compressed_out, e.instr, e.pc, e.comp);
                check("instr", instr_out, e.instr);
                check("pc", instr_pc_out, e.pc);
                check("compressed", 32'(instr_compressed_out), 32'(e.comp));
            end
        end
        if (fetch_req_out) begin
            check("one_outstanding", 32'(pend), 32'd0);
            $display("cyc %0d: fetch request %h", cyc, fetch_addr_out);
            n_req++;
            last_req_addr = fetch_addr_out;
            last_req_cyc  = cyc;
            pend      = 1'b1;
            pend_addr = fetch_addr_out;
            pend_wait = lat;
        end
        @(posedge clk);
        #1;
        cyc++;
        fetch_valid_in = 1'b0;
        fetch_word_in  = '0;
        if (pend) begin
            pend_wait--;
            if (pend_wait <= 0) begin
                pend           = 1'b0;
                fetch_valid_in = 1'b1;
                fetch_word_in  = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
                last_resp_cyc  = cyc;
            end
        end
    endtask

    task automatic push_group(input int g);
        exp_t e;
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].grp == g) begin
                e.instr = tbl[i].instr;
                e.pc    = tbl[i].pc;
                e.comp  = tbl[i].comp;
                sb.push_back(e);
            end
        end
    endtask

    task automatic drain(input string name, input int max_cyc);
        int k;
        k = 0;
        first_cons_cyc = -1;
        instr_ready_in = 1'b1;
        while (sb.size() != 0 && k < max_cyc) begin
            cycle();
            k++;
        end
        instr_ready_in = 1'b0;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: %0d instructions outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int k;
        int n0;
        int rcyc;
        rst            = 1'b1;
        instr_ready_in = 1'b0;
        redirect_in    = 1'b0;
        redirect_pc_in = '0;
        fetch_valid_in = 1'b0;
        fetch_word_in  = '0;

        //          grp  addr       word          instr         pc         comp
        tbl[0]  = '{0, 32'h000, 32'h00500093, 32'h00500093, 32'h000, 1'b0};
        tbl[1]  = '{0, 32'h004, 32'h00A00113, 32'h00A00113, 32'h004, 1'b0};
        tbl[2]  = '{1, 32'h200, 32'h00934095, 32'h00004095, 32'h200, 1'b1};
        tbl[3]  = '{1, 32'h204, 32'h00000000, 32'h00000093, 32'h202, 1'b0};
        tbl[4]  = '{1, 32'h208, 32'h00000000, 32'h00000000, 32'h206, 1'b1};
        tbl[5]  = '{2, 32'h100, 32'h40950001, 32'h00004095, 32'h102, 1'b1};
        tbl[6]  = '{2, 32'h104, 32'h00B00193, 32'h00B00193, 32'h104, 1'b0};
        tbl[7]  = '{3, 32'h300, 32'h00090005, 32'h00000005, 32'h300, 1'b1};
        tbl[8]  = '{3, 32'h304, 32'h000D0011, 32'h00000009, 32'h302, 1'b1};
        tbl[9]  = '{3, 32'h308, 32'h00000000, 32'h00000011, 32'h304, 1'b1};
        tbl[10] = '{3, 32'h30C, 32'h00000000, 32'h0000000D, 32'h306, 1'b1};
        for (int i = 0; i < 11; i++) mem[tbl[i].addr] = tbl[i].word;

        // Reset values
        cycle();
        cycle();
        check("rst_req", 32'(fetch_req_out), 32'd0);
        check("rst_addr", fetch_addr_out, 32'h0);
        check("rst_valid", 32'(instr_valid_out), 32'd0);
        check("rst_instr", instr_out, 32'h0);
        check("rst_pc", instr_pc_out, 32'h0);
        check("rst_comp", 32'(instr_compressed_out), 32'd0);
        rst = 1'b0;
        #1;
        check("first_req", 32'(fetch_req_out), 32'd1);
        check("first_addr", fetch_addr_out, 32'h0);

        // Aligned 32-bit stream
        lat = 1;
        push_group(0);
        drain("aligned", 40);

        // Redirect coinciding with a response: word dropped, request next cycle
        k = 0;
        while (!fetch_valid_in && k < 10) begin
            cycle();
            k++;
        end
        check("resp_seen_before_redirect", 32'(fetch_valid_in), 32'd1);
        redirect_in    = 1'b1;
        redirect_pc_in = 32'h200;
        rcyc = cyc;
        cycle();
        redirect_in = 1'b0;
        #1;
        check("redir_resp_req", 32'(fetch_req_out), 32'd1);
        check("redir_resp_addr", fetch_addr_out, 32'h200);
        check("redir_resp_valid", 32'(instr_valid_out), 32'd0);
        push_group(1);
        drain("mixed", 40);
        check("redirect_latency", 32'(first_cons_cyc), 32'(rcyc + 3));

        // Halfword redirect while a fetch is outstanding
        lat = 3;
        k = 0;
        while (!(pend && !fetch_valid_in) && k < 20) begin
            cycle();
            k++;
        end
        check("outstanding_before_redirect", 32'(pend), 32'd1);
        redirect_in    = 1'b1;
        redirect_pc_in = 32'h102;
        cycle();
        redirect_in = 1'b0;
        push_group(2);
        n0 = n_req;
        k = 0;
        while (n_req == n0 && k < 20) begin
            cycle();
            k++;
        end
        check("hw_redirect_addr", last_req_addr, 32'h100);
        check("hw_req_after_discard", 32'(last_req_cyc), 32'(last_resp_cyc + 1));
        drain("halfword", 40);

        // Backpressure with RVC stream
        lat = 1;
        k = 0;
        while ((pend || k < 12) && k < 30) begin
            cycle();
            k++;
        end
        redirect_in    = 1'b1;
        redirect_pc_in = 32'h300;
        cycle();
        redirect_in = 1'b0;
        push_group(3);
        n0 = n_req;
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) begin
                #1;
                check("bp_valid", 32'(instr_valid_out), 32'd1);
                check("bp_instr", instr_out, 32'h00000005);
                check("bp_pc", instr_pc_out, 32'h300);
            end
            cycle();
        end
        check("bp_requests", 32'(n_req - n0), 32'd2);
        drain("backpressure", 20);
        check("bp_consecutive", 32'(last_cons_cyc - first_cons_cyc), 32'd3);

        // Reset while a fetch is outstanding
        k = 0;
        while ((pend || k < 8) && k < 30) begin
            cycle();
            k++;
        end
        lat = 3;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n0 = n_req;
        k = 0;
        while (n_req - n0 < 2 && k < 30) begin
            cycle();
            k++;
        end
        check("midop_second_req_addr", last_req_addr, 32'h4);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midop_late_resp_present", 32'(fetch_valid_in), 32'd1);
        #1;
        check("midop_valid", 32'(instr_valid_out), 32'd0);
        check("midop_instr", instr_out, 32'h0);
        check("midop_pc", instr_pc_out, 32'h0);
        check("midop_comp", 32'(instr_compressed_out), 32'd0);
        check("midop_addr", fetch_addr_out, 32'h0);
        check("midop_req", 32'(fetch_req_out), 32'd1);
        push_group(0);
        drain("after_reset", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
